// File: rtl/snes_pad_responder_pkg.sv
// Shared types, button map and frame builder for the SNES/NES pad responder.
package snes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Index of each button in the parallel Buttons vector.
    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    localparam int SNES_FRAME_LEN = 16;
    localparam int NES_FRAME_LEN  = 8;
    localparam int CNT_W          = $clog2(SNES_FRAME_LEN);

    // Debug view of the frame engine.
    typedef struct packed {
        state_t           state;
        logic [CNT_W-1:0] bit_cnt;
    } dbg_t;

    // Bit 0 is sent first. Line level is active-low, unused slots read as 1.
    function automatic logic [15:0] build_frame(input logic [11:0] buttons, input logic mode);
        logic [15:0] f;
        f = '1;
        if (mode) begin
            f[0] = ~buttons[BTN_A];
            f[1] = ~buttons[BTN_B];
            f[2] = ~buttons[BTN_SELECT];
            f[3] = ~buttons[BTN_START];
            f[4] = ~buttons[BTN_UP];
            f[5] = ~buttons[BTN_DOWN];
            f[6] = ~buttons[BTN_LEFT];
            f[7] = ~buttons[BTN_RIGHT];
        end else begin
            f[11:0] = ~buttons;
        end
        return f;
    endfunction

endpackage

// File: rtl/snes_pad_responder_if.sv
// Pad-side bundle: host pins, button inputs and status outputs.
// Protocol: the host raises Latch to capture buttons; after Latch falls each
// ShiftClock rising edge advances Data to the next active-low bit. There is
// no backpressure: Latch/ShiftClock are asynchronous strobes and every
// detected edge is acted on (or deliberately ignored) in the cycle it is seen.
interface snes_pad_responder_if;
    import snes_pkg::*;

    logic        Mode;
    logic [11:0] Buttons;
    logic        Latch;
    logic        ShiftClock;
    logic        Data;
    logic        Busy;
    logic        FrameDone;
    dbg_t        dbg;

    modport master (
        output Mode, Buttons, Latch, ShiftClock,
        input  Data, Busy, FrameDone, dbg
    );

    modport slave (
        input  Mode, Buttons, Latch, ShiftClock,
        output Data, Busy, FrameDone, dbg
    );

endinterface

// File: rtl/snes_pad_responder_sync_edge_detect.sv
// Multi-flop synchronizer followed by a one-flop edge detector.
// SYNC_STAGES must be at least 2.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic In,
    output logic Level,
    output logic Rise,
    output logic Fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchronizer chain plus previous-level flop for edge detection.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], In};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign Level = sync_q[SYNC_STAGES-1];
    assign Rise  = Level & ~prev_q;
    assign Fall  = ~Level & prev_q;

endmodule

// File: rtl/snes_pad_responder.sv
// Controller-side SNES/NES pad: latches buttons and shifts them out on Data.
module snes_pad_responder
    import snes_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input logic                 CLK,
    input logic                 RST,
    snes_pad_responder_if.slave pad
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic latch_level, latch_rise, latch_fall;
    logic sc_level, sc_rise, sc_fall;
    logic unused_sync;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
        .CLK(CLK), .RST(RST), .In(pad.Latch),
        .Level(latch_level), .Rise(latch_rise), .Fall(latch_fall)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sc_sync (
        .CLK(CLK), .RST(RST), .In(pad.ShiftClock),
        .Level(sc_level), .Rise(sc_rise), .Fall(sc_fall)
    );

    assign unused_sync = ^{latch_level, sc_level, sc_fall};

    state_t           state_q, state_d;
    logic [15:0]      sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             mode_q, mode_d;
    logic             data_q, data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] last_bit;
    logic [15:0]      live_frame;
    logic [15:0]      rise_frame;

    // State and datapath registers; reset leaves Data high and the frame idle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            sr_q    <= '1;
            cnt_q   <= '0;
            tmo_q   <= '0;
            mode_q  <= 1'b0;
            data_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; a Latch rise always wins over anything else.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        mode_d     = mode_q;
        data_d     = data_q;
        done_d     = 1'b0;
        last_bit   = mode_q ? CNT_W'(NES_FRAME_LEN - 1) : CNT_W'(SNES_FRAME_LEN - 1);
        live_frame = build_frame(pad.Buttons, mode_q);
        rise_frame = build_frame(pad.Buttons, pad.Mode);

        if (latch_rise) begin
            // Capture Mode now so Data reflects the new frame without extra delay.
            state_d = LATCH;
            mode_d  = pad.Mode;
            sr_d    = rise_frame;
            data_d  = rise_frame[0];
            cnt_d   = '0;
            tmo_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    data_d = 1'b1;
                end
                LATCH: begin
                    if (latch_fall) begin
                        state_d = SHIFT;
                        cnt_d   = '0;
                        tmo_d   = '0;
                    end else begin
                        sr_d   = live_frame;
                        data_d = live_frame[0];
                    end
                end
                SHIFT: begin
                    if (sc_rise) begin
                        tmo_d = '0;
                        if (cnt_q == last_bit) begin
                            state_d = DONE;
                            data_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            sr_d   = {1'b1, sr_q[15:1]};
                            data_d = sr_q[1];
                            if (cnt_q != '1) begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        state_d = IDLE;
                        data_d  = 1'b1;
                        sr_d    = '1;
                        cnt_d   = '0;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                DONE: begin
                    data_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                    data_d  = 1'b1;
                end
            endcase
        end

        busy_d = (state_d == LATCH) || (state_d == SHIFT);
    end

    assign pad.Data          = data_q;
    assign pad.Busy          = busy_q;
    assign pad.FrameDone     = done_q;
    assign pad.dbg.state     = state_q;
    assign pad.dbg.bit_cnt   = cnt_q;

endmodule

// File: doc/snes_pad_responder.md
Name: snes_pad_responder

Overview:
- Controller-side end of the SNES/NES serial pad protocol: receives Latch and Shift Clock from a host poller and shifts out button states on the Data line.
- Lets the board emulate a pad, for example for loopback testing of the console-side SNES input reader or for feeding another console.
- Button states arrive as a parallel active-high vector from game logic or switches.

Parameters:
- SYNC_STAGES, 2, flip-flop stages in each input synchronizer (minimum 2).
- TIMEOUT_CYCLES, 65535, CLK cycles with no Shift Clock edge in SHIFT before the frame is abandoned.

Ports:
- CLK  input  1  system clock.
- RST  input  1  asynchronous, active-high reset.
- Mode  input  1  0 = SNES 16-bit frame, 1 = NES 8-bit frame; sampled only on Latch rising edge.
- Buttons  input  12  active-high pressed. SNES index order: 0 B, 1 Y, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right, 8 A, 9 X, 10 L, 11 R. NES frame uses 8 A, 0 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right.
- Latch  input  1  host strobe/latch, asynchronous to CLK.
- ShiftClock  input  1  host shift clock, asynchronous to CLK.
- Data  output  1  serial data to host, active-low (0 = pressed), registered.
- Busy  output  1  high while a frame is in progress (states LATCH or SHIFT).
- FrameDone  output  1  one-CLK pulse when the last frame bit has been shifted out.

Behaviour:
- Synchronization:
  - Latch and ShiftClock each pass through SYNC_STAGES flops, then a 1-flop edge detector.
  - Latency from a pin edge to the resulting Data change is SYNC_STAGES+1 CLK cycles (3 by default).
- Reset (async assert, sync release): state IDLE, Data=1, Busy=0, FrameDone=0, shift register all ones, bit counter 0.
- States:
  - IDLE: Data=1. Latch rise -> LATCH.
  - LATCH: every cycle, reload the shift register with the inverted frame (SNES: 12 buttons followed by 4 constant ones; NES: 8 buttons in NES order) and drive Data = inverted first bit. Live button changes are tracked while Latch is high. Latch fall -> SHIFT with counter 0; the shift register freezes.
  - SHIFT: each ShiftClock rising edge shifts by one and increments the counter, and Data presents the next bit. When counter reaches FRAME_LEN-1 (15 SNES, 7 NES) and another rise arrives -> DONE.
  - DONE: Data=0, as an official pad drives low after the frame. FrameDone pulses for 1 cycle on entry. Latch rise -> LATCH.
- Boundary conditions:
  - ShiftClock edges in IDLE or LATCH are ignored.
  - Latch rise in SHIFT or DONE aborts the current frame, goes to LATCH and reloads; FrameDone does not pulse on abort.
  - Mode is captured on Latch rise. A Mode change mid-frame has no effect until the next latch.
  - Simultaneous Latch rise and ShiftClock rise in the same cycle: the latch wins and the shift is discarded.
  - SHIFT idle timeout: after TIMEOUT_CYCLES with no ShiftClock rise, go to IDLE with Data=1 and no FrameDone.
  - The counter is sized by $clog2(16) and saturates; it never wraps into a new frame.
  - RST asserted mid-frame immediately forces Data=1 and IDLE.
- Busy = (state==LATCH || state==SHIFT), registered.

Decomposition:
- Package snes_pkg holds:
  - the state enum {IDLE, LATCH, SHIFT, DONE};
  - button index localparams (BTN_B ... BTN_R);
  - SNES_FRAME_LEN=16 and NES_FRAME_LEN=8;
  - a function building the 16-bit inverted frame from Buttons and Mode.
- Sub-module sync_edge_detect (parameter SYNC_STAGES; ports CLK, RST, In, Level, Rise, Fall) is instantiated twice, for Latch and for ShiftClock.

Test Plan:
- Reset, then idle 100 cycles -> Data=1, Busy=0, FrameDone=0.
- SNES frame with Buttons=12'b0000_0001_0001 (B, Up) -> 16 samples taken before each shift are 0,1,1,1,0,1,1,1,1,1,1,1,1,1,1,1. After the 16th shift, Data=0 and FrameDone pulses once. Data transitions occur 3 CLKs after each pin edge.
- NES frame with Mode=1 and Buttons with A (bit 8) and Right (bit 7) set -> 8 bits 0,1,1,1,1,1,1,0, then Data=0.
- Abort: a Latch pulse after 5 shifts -> frame restarts from the first bit with no FrameDone. Simultaneous Latch and ShiftClock rise -> counter stays 0.
- Timeout: stop ShiftClock after 3 shifts with TIMEOUT_CYCLES=100 -> IDLE and Data=1 at cycle 100.
- Assert RST mid-shift -> Data=1 and Busy=0 within the same cycle (asynchronous); a following normal frame is correct.
